rob_complete_arbiter: RTL and testbench
=======================================

// Module: rob_complete_arbiter
// PURPOSE
//  Shares the single reorder-buffer completion write port between three producers: ALU (src 0),
//  MUL pipeline (src 1) and data-cache/load return (src 2). Each source has a small completion FIFO.
//  A round-robin arbiter drains one completion per cycle into the ROB through a registered output.
//  Sits between the execute/memory stages and the ROB (in_complete/in_complete_idx/value/exception).
// PARAMETERS
//  FIFO_DEPTH  2   entries per source FIFO (>=1)
//  IDX_W       4   ROB index width
//  DATA_W      32  completion value width
// PORTS
//  clk                 in   1           clock, rising edge
//  reset               in   1           asynchronous, active-high
//  in_flush            in   1           sync flush (exception/mispredict nuke); drops all pending
//  in_valid            in   3           per-source completion valid, bit i = src i
//  in_idx              in   3*IDX_W     per-source ROB index, src i at [i*IDX_W +: IDX_W]
//  in_value            in   3*DATA_W    per-source result value, src i at [i*DATA_W +: DATA_W]
//  in_exception        in   9           per-source exception code, src i at [i*3 +: 3]
//  out_ready           out  3           per-source ready (FIFO not full, no flush)
//  out_complete        out  1           completion strobe to ROB, one cycle per entry
//  out_complete_idx    out  IDX_W       ROB index to mark complete
//  out_complete_value  out  DATA_W      value to write into the ROB entry
//  out_exception       out  3           exception code to write into the ROB entry
//  out_busy            out  1           any source FIFO non-empty
// BEHAVIOUR
//  Reset (async, immediate): all FIFO counts/pointers 0; rr_ptr=0; out_complete=0;
//   out_complete_idx/value/exception=0. out_ready=3'b111 and out_busy=0 after reset.
//  Handshake: push src i at posedge when in_valid[i] && out_ready[i]. Sources hold valid/data until
//   accepted. out_ready[i] = (count_i != FIFO_DEPTH) && !in_flush; depends only on count, not on a
//   same-cycle pop (full FIFO stays not-ready the cycle it is popped).
//  Arbitration (combinational, every cycle): candidates = non-empty FIFOs. Scan sources starting at
//   rr_ptr, wrapping 2->0; first non-empty one wins. Winner's head is popped at posedge and
//   registered onto out_complete_*; rr_ptr <= (winner+1) mod 3. No candidate: out_complete<=0, rr_ptr
//   unchanged, out_complete_idx/value/exception hold last value.
//  Latency: data accepted at edge t -> FIFO head in cycle t+1 -> out_complete high in cycle t+2
//   (min 2 cycles). Throughput: 1 completion/cycle total; each source guaranteed >=1 grant per 3.
//  Per-source FIFO order is strict FIFO; no ordering guarantee across sources.
//  Simultaneous push+pop on same FIFO: count unchanged, pointers both advance (mod FIFO_DEPTH).
//  Pointer wrap: rd/wr pointers wrap FIFO_DEPTH-1 -> 0; count tracks 0..FIFO_DEPTH.
//  Flush: at posedge with in_flush=1: all counts/pointers -> 0, rr_ptr -> 0, out_complete <= 0,
//   pushes that cycle discarded, no pop/grant. Flush takes priority over push and pop.
//  Reset mid-operation: pending entries lost, output strobe drops immediately (async).
//  No ROB backpressure: ROB accepts completions every cycle incl. stalled cycles.
//  Idx/exception passed through unmodified; no duplicate-idx checking.
//  out_busy = |(count_i != 0), combinational.
// TESTING
//  1 ALU idx=3 value=0xDEADBEEF exc=0 at edge t -> out_complete=1 only in cycle t+2, idx=3,
//    value=0xDEADBEEF, exc=0; out_busy=1 in cycle t+1 only.
//  2 All 3 sources push same edge (idx 1,2,3) after reset -> strobes on 3 consecutive cycles in
//    order idx 1,2,3; rr_ptr back to 0; out_busy low after last pop.
//  3 MUL valid held high with 6 entries, ALU pushes 3 -> grants alternate ALU/MUL while both pending;
//    out_ready[1] drops when MUL FIFO holds 2; all 9 drain, per-source order preserved.
//  4 MEM idx=7 value=0x1000 exc=3'b010 -> ROB sees idx=7 value=0x1000 exc=3'b010 unchanged.
//  5 Fill all FIFOs, assert in_flush 1 cycle with in_valid=3'b111 -> no further out_complete, pushes
//    that cycle dropped, out_ready=3'b111 next cycle, next grant starts from src 0.
//  6 Assert reset asynchronously mid-drain (between edges) -> out_complete=0 immediately;
//    after release, fresh push idx=5 completes 2 cycles later.

Source files
------------

// File: rtl/rob_complete_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rob_complete_arbiter                                         |
// | Description : Three per-source completion FIFOs (ALU, MUL, load return)    |
// |               drained one entry per cycle, round-robin, onto the single    |
// |               registered ROB completion write port.                        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module rob_complete_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int IDX_W      = 4,
  parameter int DATA_W     = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_flush,
  input  logic [2:0]          in_valid,
  input  logic [3*IDX_W-1:0]  in_idx,
  input  logic [3*DATA_W-1:0] in_value,
  input  logic [8:0]          in_exception,
  output logic [2:0]          out_ready,
  output logic                out_complete,
  output logic [IDX_W-1:0]    out_complete_idx,
  output logic [DATA_W-1:0]   out_complete_value,
  output logic [2:0]          out_exception,
  output logic                out_busy
);

  localparam int c_num_src = 3;
  localparam int c_exc_w   = 3;
  localparam int c_ptr_w   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w   = $clog2(FIFO_DEPTH + 1);
  localparam int c_ent_w   = c_exc_w + IDX_W + DATA_W;

  localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(FIFO_DEPTH - 1);
  localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  // Circular pointer advance, wrapping the last slot back to zero
  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] ptr);
    return (ptr == c_ptr_last) ? '0 : (ptr + c_ptr_one);
  endfunction

  // Per-source status/head exported from the FIFO generate block
  logic [c_num_src-1:0]              w_nonempty;
  logic [c_num_src-1:0][c_ent_w-1:0] w_head;
  logic [c_num_src-1:0]              w_pop;

  // Arbiter result
  logic       w_grant_valid;
  logic [1:0] w_grant_src;
  logic [2:0] w_scan;

  // Round-robin pointer and registered completion port
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic              out_complete_q, out_complete_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic [DATA_W-1:0] out_value_q, out_value_d;
  logic [2:0]        out_exc_q, out_exc_d;

  // ---------------------------------------------------------------------------
  // Per-source completion FIFOs
  // ---------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < c_num_src; i++) begin : g_src
      logic [c_ent_w-1:0] mem_q [FIFO_DEPTH];
      logic [c_ent_w-1:0] mem_d [FIFO_DEPTH];
      logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
      logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
      logic [c_cnt_w-1:0] count_q, count_d;
      logic               w_push;
      logic [c_ent_w-1:0] w_entry;

      // Ready depends only on occupancy: a full FIFO stays not-ready even when popped
      assign out_ready[i]  = (count_q != c_cnt_full) && !in_flush;
      assign w_push        = in_valid[i] && out_ready[i];
      assign w_pop[i]      = w_grant_valid && !in_flush && (w_grant_src == 2'(i));
      assign w_entry       = {in_exception[i*c_exc_w +: c_exc_w],
                              in_idx[i*IDX_W +: IDX_W],
                              in_value[i*DATA_W +: DATA_W]};
      assign w_nonempty[i] = (count_q != '0);
      assign w_head[i]     = mem_q[rd_ptr_q];

      // FIFO next state: flush empties it, otherwise independent push and pop
      always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (in_flush) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end else begin
          if (w_push) begin
            mem_d[wr_ptr_q] = w_entry;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
          end
          if (w_pop[i]) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
          end
          case ({w_push, w_pop[i]})
            2'b10:   count_d = count_q + c_cnt_one;
            2'b01:   count_d = count_q - c_cnt_one;
            default: count_d = count_q;
          endcase
        end
      end

      // FIFO state registers
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < FIFO_DEPTH; k++) begin
            mem_q[k] <= '0;
          end
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          mem_q    <= mem_d;
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Arbitration and completion port
  // ---------------------------------------------------------------------------

  // Scan sources starting at rr_ptr, wrapping 2->0; first non-empty FIFO wins
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_src   = 2'd0;
    w_scan        = 3'd0;
    for (int k = 0; k < c_num_src; k++) begin
      w_scan = {1'b0, rr_ptr_q} + 3'(k);
      if (w_scan >= 3'(c_num_src)) begin
        w_scan = w_scan - 3'(c_num_src);
      end
      if (!w_grant_valid && w_nonempty[w_scan[1:0]]) begin
        w_grant_valid = 1'b1;
        w_grant_src   = w_scan[1:0];
      end
    end
  end

  // Completion register: load winner's head; data fields hold when idle
  always_comb begin
    out_complete_d = 1'b0;
    out_idx_d      = out_idx_q;
    out_value_d    = out_value_q;
    out_exc_d      = out_exc_q;
    rr_ptr_d       = rr_ptr_q;
    if (in_flush) begin
      rr_ptr_d = 2'd0;
    end else if (w_grant_valid) begin
      out_complete_d                       = 1'b1;
      {out_exc_d, out_idx_d, out_value_d}  = w_head[w_grant_src];
      rr_ptr_d = (w_grant_src == 2'd2) ? 2'd0 : (w_grant_src + 2'd1);
    end
  end

  // Arbiter pointer and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q       <= 2'd0;
      out_complete_q <= 1'b0;
      out_idx_q      <= '0;
      out_value_q    <= '0;
      out_exc_q      <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      out_complete_q <= out_complete_d;
      out_idx_q      <= out_idx_d;
      out_value_q    <= out_value_d;
      out_exc_q      <= out_exc_d;
    end
  end

  assign out_complete       = out_complete_q;
  assign out_complete_idx   = out_idx_q;
  assign out_complete_value = out_value_q;
  assign out_exception      = out_exc_q;
  assign out_busy           = |w_nonempty;

endmodule
`default_nettype wire

// File: tb/tb_rob_complete_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rob_complete_arbiter                                      |
// | Description : Scoreboard bench for rob_complete_arbiter with a queue-based |
// |               reference model, directed scenarios and random traffic.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_rob_complete_arbiter;

  localparam int DEPTH = 2;
  localparam int IW    = 4;
  localparam int DW    = 32;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] val;
    logic [2:0]    exc;
  } ent_t;

  typedef struct {
    int   cyc;
    ent_t e;
    int   src;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_flush = 1'b0;
  logic [2:0]    in_valid = '0;
  logic [3*IW-1:0] in_idx = '0;
  logic [3*DW-1:0] in_value = '0;
  logic [8:0]    in_exception = '0;
  logic [2:0]    out_ready;
  logic          out_complete;
  logic [IW-1:0] out_complete_idx;
  logic [DW-1:0] out_complete_value;
  logic [2:0]    out_exception;
  logic          out_busy;

  rob_complete_arbiter #(.FIFO_DEPTH(DEPTH), .IDX_W(IW), .DATA_W(DW)) dut (
    .clk                (clk),
    .reset              (reset),
    .in_flush           (in_flush),
    .in_valid           (in_valid),
    .in_idx             (in_idx),
    .in_value           (in_value),
    .in_exception       (in_exception),
    .out_ready          (out_ready),
    .out_complete       (out_complete),
    .out_complete_idx   (out_complete_idx),
    .out_complete_value (out_complete_value),
    .out_exception      (out_exception),
    .out_busy           (out_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference model state
  ent_t       pend [3][$];   // entries waiting to be presented by each source
  ent_t       mq   [3][$];   // model of each completion FIFO
  exp_t       exp_q[$];      // expected completions, stamped with the cycle they appear
  int         rr = 0;
  int         cyc = 0;
  logic [2:0] acc = '0;      // sources accepted at the most recent edge
  bit         flushed = 1'b0;
  int         present_pct = 100;

  // Reference model: one step per clock edge, computed from pre-edge occupancy
  always @(posedge clk or posedge reset) begin
    int   w;
    exp_t x;
    ent_t e;
    if (reset) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
      exp_q.delete();
      rr      = 0;
      acc     = '0;
      flushed = 1'b0;
    end else begin
      cyc++;
      acc     = '0;
      flushed = 1'b0;
      if (in_flush) begin
        for (int i = 0; i < 3; i++) mq[i].delete();
        rr      = 0;
        flushed = 1'b1;
      end else begin
        w = -1;
        for (int k = 0; k < 3; k++) begin
          if (w < 0 && mq[(rr + k) % 3].size() > 0) w = (rr + k) % 3;
        end
        for (int i = 0; i < 3; i++) begin
          if (in_valid[i] && mq[i].size() < DEPTH) begin
            e.idx = in_idx[i*IW +: IW];
            e.val = in_value[i*DW +: DW];
            e.exc = in_exception[i*3 +: 3];
            acc[i] = 1'b1;
            if (i == w) begin
              x.e = mq[i].pop_front();
              mq[i].push_back(e);
              w = -2 - i;
            end else begin
              mq[i].push_back(e);
            end
          end
        end
        if (w <= -2) w = -2 - w;
        if (w >= 0) begin
          if (!acc[w] || x.e === 'x) x.e = mq[w].pop_front();
          x.cyc = cyc;
          x.src = w;
          exp_q.push_back(x);
          rr = (w + 1) % 3;
        end
      end
    end
  end

  // Source driver: presents pending entries, holds until accepted
  always @(posedge clk) begin
    ent_t e;
    #2;
    for (int i = 0; i < 3; i++) begin
      if (reset || flushed) begin
        in_valid[i] = 1'b0;
        pend[i].delete();
      end else begin
        if (acc[i]) in_valid[i] = 1'b0;
        if (!in_valid[i] && pend[i].size() > 0 && $urandom_range(99) < present_pct) begin
          e = pend[i].pop_front();
          in_idx[i*IW +: IW]       = e.idx;
          in_value[i*DW +: DW]     = e.val;
          in_exception[i*3 +: 3]   = e.exc;
          in_valid[i]              = 1'b1;
        end
      end
    end
  end

  // Monitor: compares every DUT completion against the scoreboard front
  always @(negedge clk) begin
    exp_t       x;
    logic [2:0] rdy;
    logic       busy;
    rdy  = '0;
    busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rdy[i] = (mq[i].size() < DEPTH) && !in_flush;
      if (mq[i].size() != 0) busy = 1'b1;
    end
    chk("out_ready", {61'd0, out_ready}, {61'd0, rdy});
    chk("out_busy", {63'd0, out_busy}, {63'd0, busy});
    if (out_complete) begin
      if (exp_q.size() == 0) begin
        chk("cpl_unexpected", {63'd0, out_complete}, 64'd0);
      end else begin
        x = exp_q.pop_front();
        chk("cpl_cycle", 64'(cyc), 64'(x.cyc));
        chk("cpl_idx", {60'd0, out_complete_idx}, {60'd0, x.e.idx});
        chk("cpl_value", {32'd0, out_complete_value}, {32'd0, x.e.val});
        chk("cpl_exc", {61'd0, out_exception}, {61'd0, x.e.exc});
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      chk("cpl_missing", {63'd0, out_complete}, 64'd1);
      void'(exp_q.pop_front());
    end
  end

  task automatic push_ent(input int s, input logic [IW-1:0] idx,
                          input logic [DW-1:0] val, input logic [2:0] exc);
    ent_t e;
    e.idx = idx;
    e.val = val;
    e.exc = exc;
    pend[s].push_back(e);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 300 && !idle; n++) begin
      @(posedge clk); #3;
      idle = (in_valid == 3'b000) && (exp_q.size() == 0);
      for (int i = 0; i < 3; i++) begin
        if (pend[i].size() != 0 || mq[i].size() != 0) idle = 1'b0;
      end
    end
    @(posedge clk); #3;
    chk("drain_idle", {63'd0, idle}, 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_complete", {63'd0, out_complete}, 64'd0);
    chk("rst_idx", {60'd0, out_complete_idx}, 64'd0);
    chk("rst_value", {32'd0, out_complete_value}, 64'd0);
    chk("rst_exc", {61'd0, out_exception}, 64'd0);
    @(posedge clk); #3;
    reset = 1'b0;

    // Single ALU completion
    push_ent(0, 4'd3, 32'hDEADBEEF, 3'd0);
    wait_idle();

    // All three sources in the same cycle
    push_ent(0, 4'd1, 32'h11, 3'd0);
    push_ent(1, 4'd2, 32'h22, 3'd0);
    push_ent(2, 4'd3, 32'h33, 3'd0);
    wait_idle();

    // Load return with exception code passed through
    push_ent(2, 4'd7, 32'h1000, 3'b010);
    wait_idle();

    // MUL backlog of 6 against 3 ALU entries
    for (int k = 0; k < 6; k++) push_ent(1, 4'(k), 32'h100 + k, 3'(k));
    for (int k = 0; k < 3; k++) push_ent(0, 4'(8 + k), 32'h200 + k, 3'(k + 1));
    wait_idle();

    // Fill all FIFOs, then flush with every source still valid
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 4; k++) push_ent(s, 4'(s * 4 + k), 32'h300 + s * 16 + k, 3'(k));
    repeat (4) @(posedge clk);
    #3;
    in_flush = 1'b1;
    @(posedge clk); #3;
    in_flush = 1'b0;
    push_ent(1, 4'd9, 32'hAA, 3'd1);
    push_ent(0, 4'd8, 32'hBB, 3'd2);
    wait_idle();

    // Asynchronous reset in the middle of a drain
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 3; k++) push_ent(s, 4'(s * 3 + k), 32'h400 + s * 16 + k, 3'(s));
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("pre_reset_strobe", {63'd0, out_complete}, 64'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_complete", {63'd0, out_complete}, 64'd0);
    chk("async_rst_busy", {63'd0, out_busy}, 64'd0);
    chk("async_rst_ready", {61'd0, out_ready}, 64'd7);
    @(posedge clk); #3;
    reset = 1'b0;
    push_ent(0, 4'd5, 32'h5555, 3'd0);
    wait_idle();

    // Randomized traffic with occasional flushes
    present_pct = 60;
    for (int n = 0; n < 500; n++) begin
      @(posedge clk); #3;
      for (int s = 0; s < 3; s++) begin
        if (pend[s].size() < 3 && $urandom_range(1) == 1)
          push_ent(s, 4'($urandom), $urandom, 3'($urandom));
      end
      in_flush = ($urandom_range(59) == 0);
    end
    in_flush = 1'b0;
    present_pct = 100;
    wait_idle();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
